// File: rtl/ondra_ps2_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : ondra_ps2_keymatrix
//  Description : PS/2 key events -> Ondra SPO186 10x5 keyboard matrix, with
//                joystick merge on column 9 and Ctrl+Alt+Del soft reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ondra_ps2_keymatrix #(
  parameter int NCOLS = 10,
  parameter int NROWS = 5
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [10:0]      ps2_key,
  input  logic [NROWS-1:0] joy,
  input  logic [3:0]       kb_col_sel,
  output logic [NROWS-1:0] kb_data,
  output logic             soft_reset_req,
  output logic [5:0]       keys_down
);

  localparam int         JOY_COL  = 9;
  localparam logic [5:0] MAX_KEYS = 6'd50;

  // Returns {valid, col[3:0], row[2:0]} for an {extended, scancode} pair.
  function automatic logic [7:0] keymap(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    case ({ext, code})
      9'h01C: m = {1'b1, 4'd0, 3'd0};  // A
      9'h01B: m = {1'b1, 4'd0, 3'd1};  // S
      9'h023: m = {1'b1, 4'd0, 3'd2};  // D
      9'h02B: m = {1'b1, 4'd0, 3'd3};  // F
      9'h034: m = {1'b1, 4'd0, 3'd4};  // G
      9'h016: m = {1'b1, 4'd1, 3'd0};  // 1
      9'h01E: m = {1'b1, 4'd1, 3'd1};  // 2
      9'h026: m = {1'b1, 4'd1, 3'd2};  // 3
      9'h025: m = {1'b1, 4'd1, 3'd3};  // 4
      9'h02E: m = {1'b1, 4'd1, 3'd4};  // 5
      9'h015: m = {1'b1, 4'd2, 3'd0};  // Q
      9'h01D: m = {1'b1, 4'd2, 3'd1};  // W
      9'h024: m = {1'b1, 4'd2, 3'd2};  // E
      9'h02D: m = {1'b1, 4'd2, 3'd3};  // R
      9'h02C: m = {1'b1, 4'd2, 3'd4};  // T
      9'h045: m = {1'b1, 4'd3, 3'd0};  // 0
      9'h046: m = {1'b1, 4'd3, 3'd1};  // 9
      9'h03E: m = {1'b1, 4'd3, 3'd2};  // 8
      9'h03D: m = {1'b1, 4'd3, 3'd3};  // 7
      9'h036: m = {1'b1, 4'd3, 3'd4};  // 6
      9'h04D: m = {1'b1, 4'd4, 3'd0};  // P
      9'h044: m = {1'b1, 4'd4, 3'd1};  // O
      9'h043: m = {1'b1, 4'd4, 3'd2};  // I
      9'h03C: m = {1'b1, 4'd4, 3'd3};  // U
      9'h035: m = {1'b1, 4'd4, 3'd4};  // Y
      9'h04B: m = {1'b1, 4'd5, 3'd0};  // L
      9'h042: m = {1'b1, 4'd5, 3'd1};  // K
      9'h03B: m = {1'b1, 4'd5, 3'd2};  // J
      9'h033: m = {1'b1, 4'd5, 3'd3};  // H
      9'h066: m = {1'b1, 4'd5, 3'd4};  // Backspace
      9'h03A: m = {1'b1, 4'd6, 3'd0};  // M
      9'h031: m = {1'b1, 4'd6, 3'd1};  // N
      9'h032: m = {1'b1, 4'd6, 3'd2};  // B
      9'h175: m = {1'b1, 4'd6, 3'd3};  // Up arrow
      9'h02A: m = {1'b1, 4'd6, 3'd4};  // V
      9'h012: m = {1'b1, 4'd7, 3'd0};  // Left Shift
      9'h059: m = {1'b1, 4'd7, 3'd0};  // Right Shift
      9'h01A: m = {1'b1, 4'd7, 3'd1};  // Z
      9'h022: m = {1'b1, 4'd7, 3'd2};  // X
      9'h021: m = {1'b1, 4'd7, 3'd3};  // C
      9'h172: m = {1'b1, 4'd7, 3'd4};  // Down arrow
      9'h16B: m = {1'b1, 4'd8, 3'd0};  // Left arrow
      9'h174: m = {1'b1, 4'd8, 3'd1};  // Right arrow
      9'h029: m = {1'b1, 4'd8, 3'd2};  // Space
      9'h041: m = {1'b1, 4'd8, 3'd3};  // Comma
      9'h05A: m = {1'b1, 4'd8, 3'd4};  // Enter
      9'h076: m = {1'b1, 4'd9, 3'd0};  // Esc
      9'h00D: m = {1'b1, 4'd9, 3'd1};  // Tab
      9'h058: m = {1'b1, 4'd9, 3'd2};  // Caps Lock
      9'h04E: m = {1'b1, 4'd9, 3'd3};  // Minus
      9'h049: m = {1'b1, 4'd9, 3'd4};  // Period
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Stage 0: strobe edge detect and event capture
  logic       strobe_ref_q, strobe_ref_d;
  logic       ev0_vld_q, ev0_vld_d;
  logic [9:0] ev0_key_q, ev0_key_d;

  // Stage 1: registered keymap lookup
  logic       ev1_vld_q, ev1_vld_d;
  logic       ev1_pressed_q, ev1_pressed_d;
  logic       ev1_ext_q, ev1_ext_d;
  logic [7:0] ev1_code_q, ev1_code_d;
  logic       map_vld_q, map_vld_d;
  logic [3:0] map_col_q, map_col_d;
  logic [2:0] map_row_q, map_row_d;
  logic [7:0] map_ent;

  // Stage 2: matrix, key count, modifiers
  logic [NCOLS-1:0][NROWS-1:0] matrix_q, matrix_d;
  logic [5:0]                  keys_down_q, keys_down_d;
  logic                        ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
  logic                        alt_l_q, alt_l_d, alt_r_q, alt_r_d;
  logic                        soft_reset_q, soft_reset_d;
  logic                        hit, old_bit;

  // Read path
  logic [NROWS-1:0] kb_data_q, kb_data_d;
  logic [NROWS-1:0] rd_bits;
  logic             rd_in_range;

  always_comb begin
    strobe_ref_d = ps2_key[10];
    ev0_vld_d    = (ps2_key[10] != strobe_ref_q);
    ev0_key_d    = ev0_vld_d ? ps2_key[9:0] : ev0_key_q;
  end

  always_comb begin
    map_ent       = keymap(ev0_key_q[8], ev0_key_q[7:0]);
    ev1_vld_d     = ev0_vld_q;
    ev1_pressed_d = ev0_key_q[9];
    ev1_ext_d     = ev0_key_q[8];
    ev1_code_d    = ev0_key_q[7:0];
    map_vld_d     = ev0_vld_q & map_ent[7];
    map_col_d     = map_ent[6:3];
    map_row_d     = map_ent[2:0];
  end

  always_comb begin
    matrix_d = matrix_q;
    hit      = 1'b0;
    old_bit  = 1'b0;
    for (int c = 0; c < NCOLS; c++) begin
      for (int r = 0; r < NROWS; r++) begin
        if (map_vld_q && (map_col_q == 4'(c)) && (map_row_q == 3'(r))) begin
          hit            = 1'b1;
          old_bit        = matrix_q[c][r];
          matrix_d[c][r] = ev1_pressed_q;
        end
      end
    end
    // Only a real bit transition moves the counter; repeats are no-ops.
    keys_down_d = keys_down_q;
    if (hit && (old_bit != ev1_pressed_q)) begin
      if (ev1_pressed_q) begin
        if (keys_down_q < MAX_KEYS) keys_down_d = keys_down_q + 6'd1;
      end else if (keys_down_q != 6'd0) begin
        keys_down_d = keys_down_q - 6'd1;
      end
    end
  end

  // Left and right modifiers tracked separately so releasing one side
  // does not drop the state while the other side is still held.
  always_comb begin
    ctrl_l_d     = ctrl_l_q;
    ctrl_r_d     = ctrl_r_q;
    alt_l_d      = alt_l_q;
    alt_r_d      = alt_r_q;
    soft_reset_d = 1'b0;
    if (ev1_vld_q) begin
      if (ev1_code_q == 8'h14) begin
        if (ev1_ext_q) ctrl_r_d = ev1_pressed_q;
        else           ctrl_l_d = ev1_pressed_q;
      end
      if (ev1_code_q == 8'h11) begin
        if (ev1_ext_q) alt_r_d = ev1_pressed_q;
        else           alt_l_d = ev1_pressed_q;
      end
      if (ev1_ext_q && (ev1_code_q == 8'h71) && ev1_pressed_q &&
          (ctrl_l_q || ctrl_r_q) && (alt_l_q || alt_r_q)) begin
        soft_reset_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_bits     = '0;
    rd_in_range = 1'b0;
    for (int c = 0; c < NCOLS; c++) begin
      if (kb_col_sel == 4'(c)) begin
        rd_in_range = 1'b1;
        rd_bits     = matrix_q[c];
        if (c == JOY_COL) rd_bits = rd_bits | joy;
      end
    end
    kb_data_d = rd_in_range ? ~rd_bits : '1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      strobe_ref_q  <= ps2_key[10];
      ev0_vld_q     <= 1'b0;
      ev0_key_q     <= '0;
      ev1_vld_q     <= 1'b0;
      ev1_pressed_q <= 1'b0;
      ev1_ext_q     <= 1'b0;
      ev1_code_q    <= '0;
      map_vld_q     <= 1'b0;
      map_col_q     <= '0;
      map_row_q     <= '0;
      matrix_q      <= '0;
      keys_down_q   <= '0;
      ctrl_l_q      <= 1'b0;
      ctrl_r_q      <= 1'b0;
      alt_l_q       <= 1'b0;
      alt_r_q       <= 1'b0;
      soft_reset_q  <= 1'b0;
      kb_data_q     <= '1;
    end else begin
      strobe_ref_q  <= strobe_ref_d;
      ev0_vld_q     <= ev0_vld_d;
      ev0_key_q     <= ev0_key_d;
      ev1_vld_q     <= ev1_vld_d;
      ev1_pressed_q <= ev1_pressed_d;
      ev1_ext_q     <= ev1_ext_d;
      ev1_code_q    <= ev1_code_d;
      map_vld_q     <= map_vld_d;
      map_col_q     <= map_col_d;
      map_row_q     <= map_row_d;
      matrix_q      <= matrix_d;
      keys_down_q   <= keys_down_d;
      ctrl_l_q      <= ctrl_l_d;
      ctrl_r_q      <= ctrl_r_d;
      alt_l_q       <= alt_l_d;
      alt_r_q       <= alt_r_d;
      soft_reset_q  <= soft_reset_d;
      kb_data_q     <= kb_data_d;
    end
  end

  assign kb_data        = kb_data_q;
  assign soft_reset_req = soft_reset_q;
  assign keys_down      = keys_down_q;

endmodule
`default_nettype wire

// File: tb/tb_ondra_ps2_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ondra_ps2_keymatrix
//  Description : Vector table, corner sequences and randomized events checked
//                against a key-state reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ondra_ps2_keymatrix;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = 11'h400;
  logic [4:0]  joy     = '0;
  logic [3:0]  kb_col_sel = '0;
  logic [4:0]  kb_data;
  logic        soft_reset_req;
  logic [5:0]  keys_down;

  int checks = 0;
  int errors = 0;

  logic [4:0] model_mat [10];

  always #5 clk_sys = ~clk_sys;

  ondra_ps2_keymatrix #(.NCOLS(10), .NROWS(5)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ps2_key        (ps2_key),
    .joy            (joy),
    .kb_col_sel     (kb_col_sel),
    .kb_data        (kb_data),
    .soft_reset_req (soft_reset_req),
    .keys_down      (keys_down)
  );

  typedef struct {
    logic       pr;
    logic       ext;
    logic [7:0] code;
    logic [3:0] sel;
    logic [4:0] jy;
    logic [4:0] exp_kb;
    logic [5:0] exp_kd;
  } vec_t;

  vec_t vecs [18];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one key event (toggle the strobe) and let one edge sample it.
  task automatic post(input logic pr, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ext, code};
    tick();
  endtask

  // Keys the reference knows about; everything else in the pool is unmapped.
  task automatic ref_map(input logic ext, input logic [7:0] code,
                         output bit ok, output int col, output int row);
    ok = 1'b1; col = 0; row = 0;
    if      (!ext && code == 8'h1C) begin col = 0; row = 0; end
    else if (!ext && code == 8'h1B) begin col = 0; row = 1; end
    else if (!ext && code == 8'h16) begin col = 1; row = 0; end
    else if (!ext && code == 8'h29) begin col = 8; row = 2; end
    else if (!ext && code == 8'h5A) begin col = 8; row = 4; end
    else if (!ext && (code == 8'h12 || code == 8'h59)) begin col = 7; row = 0; end
    else if ( ext && code == 8'h75) begin col = 6; row = 3; end
    else ok = 1'b0;
  endtask

  task automatic model_clear();
    for (int c = 0; c < 10; c++) model_mat[c] = '0;
  endtask

  task automatic model_event(input logic pr, input logic ext, input logic [7:0] code);
    bit ok; int col; int row;
    ref_map(ext, code, ok, col, row);
    if (ok) model_mat[col][row] = pr;
  endtask

  function automatic logic [4:0] model_kb(input logic [3:0] sel, input logic [4:0] jy);
    logic [4:0] b;
    if (sel >= 4'd10) return 5'h1F;
    b = model_mat[sel];
    if (sel == 4'd9) b = b | jy;
    return ~b;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int c = 0; c < 10; c++) n += $countones(model_mat[c]);
    return n;
  endfunction

  function automatic int pulses(input int n);
    return n;
  endfunction

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (soft_reset_req) cnt++;
    end
  endtask

  initial begin
    int cnt;
    logic [8:0] pool [12];
    vecs[0]  = '{1'b1, 1'b0, 8'h1C, 4'd0,  5'h00, 5'h1E, 6'd1};
    vecs[1]  = '{1'b0, 1'b0, 8'h1C, 4'd0,  5'h00, 5'h1F, 6'd0};
    vecs[2]  = '{1'b1, 1'b0, 8'h16, 4'd1,  5'h00, 5'h1E, 6'd1};
    vecs[3]  = '{1'b1, 1'b0, 8'h29, 4'd8,  5'h00, 5'h1B, 6'd2};
    vecs[4]  = '{1'b1, 1'b0, 8'h5A, 4'd8,  5'h00, 5'h0B, 6'd3};
    vecs[5]  = '{1'b1, 1'b1, 8'h75, 4'd6,  5'h00, 5'h17, 6'd4};
    vecs[6]  = '{1'b1, 1'b0, 8'h12, 4'd7,  5'h00, 5'h1E, 6'd5};
    vecs[7]  = '{1'b1, 1'b0, 8'h59, 4'd7,  5'h00, 5'h1E, 6'd5};
    vecs[8]  = '{1'b0, 1'b0, 8'h59, 4'd7,  5'h00, 5'h1F, 6'd4};
    vecs[9]  = '{1'b1, 1'b0, 8'h75, 4'd6,  5'h00, 5'h17, 6'd4};
    vecs[10] = '{1'b0, 1'b0, 8'h1C, 4'd0,  5'h00, 5'h1F, 6'd4};
    vecs[11] = '{1'b0, 1'b0, 8'h16, 4'd1,  5'h00, 5'h1F, 6'd3};
    vecs[12] = '{1'b1, 1'b0, 8'h05, 4'd9,  5'h11, 5'h0E, 6'd3};
    vecs[13] = '{1'b1, 1'b0, 8'h05, 4'd10, 5'h11, 5'h1F, 6'd3};
    vecs[14] = '{1'b1, 1'b0, 8'h83, 4'd15, 5'h1F, 5'h1F, 6'd3};
    vecs[15] = '{1'b0, 1'b1, 8'h75, 4'd6,  5'h00, 5'h1F, 6'd2};
    vecs[16] = '{1'b0, 1'b0, 8'h29, 4'd8,  5'h00, 5'h0F, 6'd1};
    vecs[17] = '{1'b0, 1'b0, 8'h5A, 4'd8,  5'h00, 5'h1F, 6'd0};

    pool[0] = 9'h01C; pool[1] = 9'h01B; pool[2]  = 9'h016; pool[3]  = 9'h029;
    pool[4] = 9'h05A; pool[5] = 9'h012; pool[6]  = 9'h059; pool[7]  = 9'h175;
    pool[8] = 9'h005; pool[9] = 9'h083; pool[10] = 9'h075; pool[11] = 9'h11C;

    // Reset with strobe held high and no toggle
    ticks(2);
    reset = 1'b0;
    ticks(3);
    check("reset_keys_down", 32'(keys_down), 32'd0);
    check("reset_soft_req", 32'(soft_reset_req), 32'd0);
    for (int s = 0; s < 16; s++) begin
      kb_col_sel = 4'(s);
      tick();
      check($sformatf("reset_kb_col%0d", s), 32'(kb_data), 32'h1F);
    end

    // Vector table
    for (int i = 0; i < 18; i++) begin
      kb_col_sel = vecs[i].sel;
      joy        = vecs[i].jy;
      post(vecs[i].pr, vecs[i].ext, vecs[i].code);
      ticks(3);
      check($sformatf("vec%0d_kb", i), 32'(kb_data), 32'(vecs[i].exp_kb));
      check($sformatf("vec%0d_kd", i), 32'(keys_down), 32'(vecs[i].exp_kd));
    end
    joy = '0;

    // Back-to-back events on consecutive cycles
    kb_col_sel = 4'd0;
    post(1'b1, 1'b0, 8'h1C);
    post(1'b1, 1'b0, 8'h1B);
    ticks(3);
    check("b2b_kb", 32'(kb_data), 32'h1C);
    check("b2b_kd", 32'(keys_down), 32'd2);
    post(1'b1, 1'b0, 8'h1B);
    ticks(3);
    check("repeat_kd", 32'(keys_down), 32'd2);
    check("repeat_kb", 32'(kb_data), 32'h1C);
    post(1'b0, 1'b0, 8'h1C);
    post(1'b0, 1'b0, 8'h1B);
    ticks(3);
    check("b2b_release_kd", 32'(keys_down), 32'd0);

    // Write and read of the same column in one cycle returns the old value
    kb_col_sel = 4'd1;
    post(1'b1, 1'b0, 8'h16);
    ticks(2);
    check("same_cycle_old", 32'(kb_data), 32'h1F);
    tick();
    check("same_cycle_new", 32'(kb_data), 32'h1E);
    post(1'b0, 1'b0, 8'h16);
    ticks(3);

    // Ctrl+Alt+Del
    post(1'b1, 1'b0, 8'h14);
    post(1'b1, 1'b0, 8'h11);
    ticks(2);
    post(1'b1, 1'b1, 8'h71);
    tick();
    check("cad_pre", 32'(soft_reset_req), 32'd0);
    tick();
    check("cad_pulse", 32'(soft_reset_req), 32'd1);
    tick();
    check("cad_post", 32'(soft_reset_req), 32'd0);
    post(1'b1, 1'b1, 8'h71);
    count_pulses(6, cnt);
    check("cad_autorepeat", 32'(cnt), 32'd1);
    post(1'b0, 1'b1, 8'h71);
    post(1'b0, 1'b0, 8'h14);
    ticks(2);
    post(1'b1, 1'b1, 8'h71);
    count_pulses(6, cnt);
    check("del_no_ctrl", 32'(cnt), 32'd0);
    post(1'b1, 1'b1, 8'h14);
    ticks(2);
    post(1'b1, 1'b1, 8'h71);
    count_pulses(6, cnt);
    check("cad_right_ctrl", 32'(cnt), 32'd1);
    post(1'b0, 1'b1, 8'h14);
    post(1'b0, 1'b0, 8'h11);
    post(1'b0, 1'b1, 8'h71);
    ticks(3);

    // Reset mid-operation
    kb_col_sel = 4'd8;
    post(1'b1, 1'b0, 8'h29);
    ticks(3);
    check("pre_reset_kb", 32'(kb_data), 32'h1B);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_kb", 32'(kb_data), 32'h1F);
    check("post_reset_kd", 32'(keys_down), 32'd0);
    post(1'b0, 1'b0, 8'h29);
    ticks(3);
    check("stale_release_kb", 32'(kb_data), 32'h1F);
    check("stale_release_kd", 32'(keys_down), 32'd0);

    // In-flight event and strobe toggle during reset are both dropped
    kb_col_sel = 4'd0;
    post(1'b1, 1'b0, 8'h1C);
    reset   = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1B};
    tick();
    reset = 1'b0;
    ticks(4);
    check("inflight_kd", 32'(keys_down), 32'd0);
    check("inflight_kb", 32'(kb_data), 32'h1F);

    // Randomized bursts against the reference model
    model_clear();
    for (int it = 0; it < 200; it++) begin
      int burst;
      burst      = int'($urandom_range(1, 3));
      kb_col_sel = 4'($urandom_range(0, 15));
      joy        = 5'($urandom);
      for (int b = 0; b < burst; b++) begin
        logic [8:0] k;
        logic       pr;
        k  = pool[$urandom_range(0, 11)];
        pr = 1'($urandom);
        model_event(pr, k[8], k[7:0]);
        post(pr, k[8], k[7:0]);
      end
      ticks(3);
      check($sformatf("rnd%0d_kb", it), 32'(kb_data), 32'(model_kb(kb_col_sel, joy)));
      check($sformatf("rnd%0d_kd", it), 32'(keys_down), 32'(model_count()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ondra_ps2_keymatrix.md
Name: ondra_ps2_keymatrix

Overview:
- Consumes the PS/2 key event bus that the board top level assembles as {toggle strobe, pressed, extended, scancode}.
- Decodes each event into the Ondra SPO186 10-column x 5-row keyboard matrix and keeps the pressed state of every key.
- Serves matrix reads to the Ondra core's keyboard port, with joystick bits merged onto column 9.
- Also raises a one-cycle soft-reset request on Ctrl+Alt+Del.

Parameters:
- NCOLS, 10, number of matrix columns; column selects at or above NCOLS read as idle.
- NROWS, 5, number of rows (data bits) per column.

Ports:
- clk_sys  in  1  system clock (8 MHz domain).
- reset  in  1  synchronous, active-high.
- ps2_key  in  11  [10]=toggle strobe, [9]=1 pressed/0 released, [8]=extended (E0), [7:0]=scancode.
- joy  in  5  active-high, [4]=fire [3]=up [2]=down [1]=left [0]=right.
- kb_col_sel  in  4  column address driven by the core's keyboard port.
- kb_data  out  5  active-low row data for the selected column.
- soft_reset_req  out  1  one-cycle pulse on Ctrl+Alt+Del.
- keys_down  out  6  count of matrix keys currently held (debug/LED).

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous, active-high.
- Reset values:
  - matrix all released.
  - kb_data = 5'b11111.
  - soft_reset_req = 0.
  - keys_down = 0.
  - Ctrl/Alt flags cleared.
  - Strobe reference register loaded with the current ps2_key[10].
  - No event is generated by the first sample after reset.
- Event detect, cycle N: ps2_key[10] differs from the reference register. Capture ps2_key[9:0] and update the reference.
  - Back-to-back toggles on consecutive cycles are each accepted. The pipeline is fully pipelined at one event per cycle.
- Lookup, cycle N+1: registered map of {extended, scancode} to {valid, col[3:0], row[2:0]}.
  - Required entries:
    - 0x1C (A) -> col0 row0.
    - 0x1B (S) -> col0 row1.
    - 0x16 (1) -> col1 row0.
    - 0x29 (Space) -> col8 row2.
    - 0x5A (Enter) -> col8 row4.
    - 0x12 / 0x59 (L/R Shift) -> col9 row... no: Shift -> col7 row0.
    - E0 0x75 (Up arrow) -> col6 row3.
  - All other codes are unmapped (valid=0).
  - The full table is held in the companion keymap file.
- Update, cycle N+2: if valid, matrix[col][row] <= pressed.
  - Press of an already-pressed key: no change, keys_down unchanged.
  - Release of an already-released key: no change.
  - keys_down increments or decrements only on an actual bit change. Saturates at 0 and 50.
  - Unmapped codes leave the matrix unchanged.
- Modifier tracking at the update stage, independent of the matrix:
  - Ctrl: 0x14, with or without E0.
  - Alt: 0x11, with or without E0.
  - Del: E0 0x71.
  - Del pressed while Ctrl and Alt are held: soft_reset_req = 1 for exactly one cycle (N+2 registered, visible N+3).
  - Auto-repeat of Del while still held: a pulse per make event.
- Read path: kb_data is registered each cycle.
  - kb_col_sel < 9: kb_data = ~matrix[kb_col_sel].
  - kb_col_sel == 9: kb_data = ~(matrix[9] | joy).
  - kb_col_sel >= NCOLS: kb_data = 5'b11111.
  - Latency is one cycle from kb_col_sel change. A matrix update at cycle N+2 is visible on kb_data at N+3.
- Reset mid-operation: in-flight pipeline events are discarded. The matrix clears and the reference re-samples. Keys held across reset appear released until re-made.
- Simultaneous events: an update-stage write and a read of the same column in one cycle return the pre-write value; the new value appears on the next cycle.

Test Plan:
- Reset with ps2_key[10]=1 held, no toggle -> kb_data=5'h1F for every kb_col_sel, keys_down=0, no soft_reset_req.
- Toggle with {pressed=1, ext=0, 0x1C}, kb_col_sel=0 -> kb_data=5'b11110 three cycles after the toggle, keys_down=1. Then toggle the release -> 5'b11111, keys_down=0.
- Two toggles on consecutive cycles, press 0x1C then press 0x1B -> col0 reads 5'b11100 and keys_down=2. A repeated press of 0x1B leaves keys_down=2.
- joy=5'b10001 with no keys, kb_col_sel=9 -> kb_data=5'b01110. kb_col_sel=10 or 15 -> 5'b11111.
- Press 0x14, press 0x11, press E0 0x71 -> soft_reset_req high exactly 1 cycle. Del without Ctrl held -> no pulse.
- Press 0x29 (col8 row2), then assert reset for 1 cycle, then release 0x29 -> kb_data col8=5'b11111 after reset, release causes no change, keys_down stays 0.
